mem_port_arbiter: RTL and testbench

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/mem_arb_pkg.sv | 15 +
 rtl/rr_arbiter.sv | 39 +++
 rtl/mem_port_arbiter.sv | 206 ++++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 378 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types and widths for the memory port arbiter.
// Holds the arbiter FSM state type and the byte/length/word widths.
package mem_arb_pkg;

    localparam int BYTE_W = 8;
    localparam int LEN_W  = 2;
    localparam int WORD_W = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_XFER = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin grant selection.
// Searches from i_ptr upward (wrapping) and reports one past the winner.
module rr_arbiter #(
    parameter int N  = 3,
    parameter int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  i_req,
    input  logic [PW-1:0] i_ptr,
    output logic [N-1:0]  o_gnt,
    output logic [PW-1:0] o_ptr_nxt,
    output logic          o_any
);

    // pick the first requester at or after the pointer, wrapping round
    always_comb begin
        int v_c;
        int v_idx;
        int v_nxt;
        o_any = 1'b0;
        v_c   = 0;
        v_idx = 0;
        v_nxt = 0;
        for (int k = 0; k < N; k++) begin
            v_c = int'(i_ptr) + k;
            if (v_c >= N) v_c = v_c - N;
            for (int j = 0; j < N; j++) begin
                if (!o_any && j == v_c && i_req[j]) begin
                    o_any = 1'b1;
                    v_idx = j;
                end
            end
        end
        v_nxt = v_idx + 1;
        if (v_nxt == N) v_nxt = 0;
        o_gnt     = o_any ? (N'(1) << v_idx) : '0;
        o_ptr_nxt = o_any ? PW'(v_nxt) : i_ptr;
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one byte-wide memory port among read/write clients.
// Define MEM_ARB_WPRIO_EN to let any pending write win over all reads.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int N_RPORT = 2,
    parameter int N_WPORT = 1,
    parameter int ADDR_W  = 32
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [N_RPORT-1:0]          c_re,
    input  logic [N_RPORT*ADDR_W-1:0]   c_raddr,
    input  logic [N_RPORT*2-1:0]        c_rlen,
    output logic [N_RPORT*32-1:0]       c_rdata,
    output logic [N_RPORT-1:0]          c_rack,
    input  logic [N_WPORT-1:0]          c_we,
    input  logic [N_WPORT*ADDR_W-1:0]   c_waddr,
    input  logic [N_WPORT*2-1:0]        c_wlen,
    input  logic [N_WPORT*32-1:0]       c_wdata,
    output logic [N_WPORT-1:0]          c_wack,
    output logic [ADDR_W-1:0]           m_addr,
    output logic                        m_re,
    output logic                        m_we,
    output logic [7:0]                  m_dout,
    input  logic [7:0]                  m_din,
    input  logic                        m_ack
);

    localparam int NA = N_RPORT + N_WPORT;
    localparam int PW = (NA > 1) ? $clog2(NA) : 1;

    state_t r_state;
    state_t w_next;

    logic [PW-1:0]           r_ptr;
    logic [PW-1:0]           r_port;
    logic [PW-1:0]           w_ptr_nxt;
    logic [PW-1:0]           w_g_port;
    logic                    r_wr;
    logic                    w_g_wr;
    logic                    w_any;
    logic                    w_take;
    logic                    w_step;
    logic                    w_last;
    logic [NA-1:0]           w_req;
    logic [NA-1:0]           w_gnt;
    logic [N_RPORT-1:0]      w_rpend;
    logic [N_RPORT-1:0]      r_rack;
    logic [N_WPORT-1:0]      w_wpend;
    logic [N_WPORT-1:0]      r_wack;
    logic [ADDR_W-1:0]       r_base;
    logic [ADDR_W-1:0]       w_g_addr;
    logic [LEN_W-1:0]        r_len;
    logic [LEN_W-1:0]        r_cnt;
    logic [LEN_W-1:0]        w_g_len;
    logic [WORD_W-1:0]       r_wdata;
    logic [WORD_W-1:0]       w_g_wdata;
    logic [WORD_W-1:0]       r_buf;
    logic [WORD_W-1:0]       w_word;
    logic [N_RPORT*WORD_W-1:0] r_rdata;
    logic                    r_mre;
    logic                    r_mwe;

    // a port stops counting as pending in the cycle its ack is shown
    assign w_rpend = c_re & ~r_rack;
    assign w_wpend = c_we & ~r_wack;

`ifdef MEM_ARB_WPRIO_EN
    assign w_req = (|w_wpend) ? {w_wpend, {N_RPORT{1'b0}}}
                              : {{N_WPORT{1'b0}}, w_rpend};
`else
    assign w_req = {w_wpend, w_rpend};
`endif

    rr_arbiter #(
        .N  (NA),
        .PW (PW)
    ) u_rr (
        .i_req     (w_req),
        .i_ptr     (r_ptr),
        .o_gnt     (w_gnt),
        .o_ptr_nxt (w_ptr_nxt),
        .o_any     (w_any)
    );

    // route the granted port's request fields to the latch inputs
    always_comb begin
        w_g_addr  = '0;
        w_g_len   = '0;
        w_g_wdata = '0;
        w_g_wr    = 1'b0;
        w_g_port  = '0;
        for (int i = 0; i < N_RPORT; i++) begin
            if (w_gnt[i]) begin
                w_g_addr = c_raddr[i*ADDR_W +: ADDR_W];
                w_g_len  = c_rlen[i*2 +: 2];
                w_g_port = PW'(i);
            end
        end
        for (int j = 0; j < N_WPORT; j++) begin
            if (w_gnt[N_RPORT+j]) begin
                w_g_addr  = c_waddr[j*ADDR_W +: ADDR_W];
                w_g_len   = c_wlen[j*2 +: 2];
                w_g_wdata = c_wdata[j*32 +: 32];
                w_g_wr    = 1'b1;
                w_g_port  = PW'(j);
            end
        end
    end

    assign w_word  = r_buf | (WORD_W'(m_din) << {r_cnt, 3'b000});
    assign m_re    = r_mre;
    assign m_we    = r_mwe;
    assign m_addr  = (r_mre | r_mwe) ? r_base + ADDR_W'(r_cnt) : '0;
    assign m_dout  = r_mwe ? r_wdata[{r_cnt, 3'b000} +: BYTE_W] : '0;
    assign c_rdata = r_rdata;
    assign c_rack  = r_rack;
    assign c_wack  = r_wack;

    // state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_next;
    end

    // next state and per-cycle control strobes
    always_comb begin
        w_next = r_state;
        w_take = 1'b0;
        w_step = 1'b0;
        w_last = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (w_any) begin
                    w_take = 1'b1;
                    w_next = ST_XFER;
                end
            end
            ST_XFER: begin
                if (m_ack) begin
                    w_step = 1'b1;
                    if (r_cnt == r_len) begin
                        w_last = 1'b1;
                        w_next = ST_DONE;
                    end
                end
            end
            ST_DONE: w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    // transfer datapath: latch on grant, step per byte, publish on last
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ptr   <= '0;
            r_port  <= '0;
            r_wr    <= 1'b0;
            r_base  <= '0;
            r_len   <= '0;
            r_cnt   <= '0;
            r_wdata <= '0;
            r_buf   <= '0;
            r_rdata <= '0;
            r_rack  <= '0;
            r_wack  <= '0;
            r_mre   <= 1'b0;
            r_mwe   <= 1'b0;
        end else begin
            r_rack <= '0;
            r_wack <= '0;
            if (w_take) begin
                r_ptr   <= w_ptr_nxt;
                r_port  <= w_g_port;
                r_wr    <= w_g_wr;
                r_base  <= w_g_addr;
                r_len   <= w_g_len;
                r_wdata <= w_g_wdata;
                r_cnt   <= '0;
                r_buf   <= '0;
                r_mre   <= ~w_g_wr;
                r_mwe   <= w_g_wr;
            end
            if (w_step) begin
                if (!r_wr) r_buf <= w_word;
                if (w_last) begin
                    r_mre <= 1'b0;
                    r_mwe <= 1'b0;
                    for (int i = 0; i < N_RPORT; i++) begin
                        if (!r_wr && r_port == PW'(i)) begin
                            r_rack[i] <= 1'b1;
                            r_rdata[i*WORD_W +: WORD_W] <= w_word;
                        end
                    end
                    for (int j = 0; j < N_WPORT; j++) begin
                        if (r_wr && r_port == PW'(j)) r_wack[j] <= 1'b1;
                    end
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: randomized scoreboard bench for mem_port_arbiter.
// A byte-memory model predicts service order, bus bytes and read words.
module tb_mem_port_arbiter;

    localparam int NR = 2;
    localparam int NW = 1;
    localparam int NA = NR + NW;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic [NR-1:0]     c_re = '0;
    logic [NR*32-1:0]  c_raddr = '0;
    logic [NR*2-1:0]   c_rlen = '0;
    logic [NR*32-1:0]  c_rdata;
    logic [NR-1:0]     c_rack;
    logic [NW-1:0]     c_we = '0;
    logic [NW*32-1:0]  c_waddr = '0;
    logic [NW*2-1:0]   c_wlen = '0;
    logic [NW*32-1:0]  c_wdata = '0;
    logic [NW-1:0]     c_wack;
    logic [31:0]       m_addr;
    logic              m_re;
    logic              m_we;
    logic [7:0]        m_dout;
    logic [7:0]        m_din = '0;
    logic              m_ack = 1'b0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.N_RPORT(NR), .N_WPORT(NW), .ADDR_W(32)) dut (
        .clk(clk), .rst(rst),
        .c_re(c_re), .c_raddr(c_raddr), .c_rlen(c_rlen),
        .c_rdata(c_rdata), .c_rack(c_rack),
        .c_we(c_we), .c_waddr(c_waddr), .c_wlen(c_wlen),
        .c_wdata(c_wdata), .c_wack(c_wack),
        .m_addr(m_addr), .m_re(m_re), .m_we(m_we),
        .m_dout(m_dout), .m_din(m_din), .m_ack(m_ack)
    );

    typedef struct { logic wr; bit [31:0] addr; logic [7:0] data; } bus_t;
    typedef struct { logic wr; int port; logic [31:0] word; } cmp_t;

    bus_t bq[$];
    cmp_t cq[$];
    logic [7:0] env_mem [bit [31:0]];
    logic [7:0] mdl_mem [bit [31:0]];
    logic [31:0] exp_rdata [NR];
    logic [31:0] b_addr [NA];
    logic [1:0]  b_len [NA];
    logic [31:0] b_wdata [NA];
    int tests = 0;
    int fails = 0;
    int mptr = 0;
    int bus_acks = 0;
    int force_stall = -1;
    bit spur_en = 1'b1;

    function automatic logic [7:0] dflt(bit [31:0] a);
        return a[7:0] ^ a[15:8] ^ 8'h5A;
    endfunction

    function automatic logic [7:0] env_rd(bit [31:0] a);
        if (env_mem.exists(a)) return env_mem[a];
        return dflt(a);
    endfunction

    function automatic logic [7:0] mdl_rd(bit [31:0] a);
        if (mdl_mem.exists(a)) return mdl_mem[a];
        return dflt(a);
    endfunction

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // memory responder: random stalls, one-cycle acks, spurious idle acks
    initial begin
        int stall;
        stall = 0;
        forever begin
            @(posedge clk); #1;
            if (rst) begin
                m_ack = 1'b0;
                stall = 0;
            end else if (m_ack) begin
                m_ack = 1'b0;
            end else if (m_re || m_we) begin
                if (stall > 0) stall--;
                else begin
                    m_ack = 1'b1;
                    if (m_re) m_din = env_rd(m_addr);
                    else env_mem[m_addr] = m_dout;
                    stall = (force_stall >= 0) ? force_stall : $urandom_range(0, 3);
                end
            end else begin
                stall = (force_stall >= 0) ? force_stall : $urandom_range(0, 3);
                if (spur_en && $urandom_range(0, 3) == 0) begin
                    m_ack = 1'b1;
                    m_din = 8'($urandom);
                end
            end
        end
    end

    // requesters drop their request the cycle after seeing their ack
    initial begin
        logic [NR-1:0] ar;
        logic [NW-1:0] aw;
        forever begin
            @(negedge clk);
            ar = c_rack;
            aw = c_wack;
            @(posedge clk); #1;
            c_re = c_re & ~ar;
            c_we = c_we & ~aw;
        end
    end

    // monitor: pops bus and completion scoreboards as the DUT presents them
    initial begin
        logic [NR-1:0] prev_r;
        logic [NW-1:0] prev_w;
        bus_t eb;
        cmp_t ec;
        prev_r = '0;
        prev_w = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_r = '0;
                prev_w = '0;
            end else begin
                if (m_re || m_we) check("strobe_excl", {31'd0, m_re & m_we}, 32'd0);
                if (m_ack && (m_re || m_we)) begin
                    bus_acks++;
                    if (bq.size() == 0) begin
                        tests++; fails++;
                        $display("FAIL bus_unexpected: addr %h with no expected byte", m_addr);
                    end else begin
                        eb = bq.pop_front();
                        check("bus_dir", {31'd0, m_we}, {31'd0, eb.wr});
                        check("bus_addr", m_addr, eb.addr);
                        if (eb.wr) check("bus_wdata", {24'd0, m_dout}, {24'd0, eb.data});
                    end
                end
                for (int i = 0; i < NA; i++) begin
                    logic hit;
                    logic was;
                    hit = (i < NR) ? c_rack[i % NR] : c_wack[(i - NR) % NW];
                    was = (i < NR) ? prev_r[i % NR] : prev_w[(i - NR) % NW];
                    if (hit) begin
                        check("ack_pulse", {31'd0, was}, 32'd0);
                        if (cq.size() == 0) begin
                            tests++; fails++;
                            $display("FAIL ack_unexpected: port index %0d acked with none due", i);
                        end else begin
                            ec = cq.pop_front();
                            check("ack_order", 32'(i), ec.wr ? 32'(NR + ec.port) : 32'(ec.port));
                            if (i < NR)
                                check("rdata", c_rdata[(i % NR)*32 +: 32], ec.word);
                        end
                    end
                end
                prev_r = c_rack;
                prev_w = c_wack;
            end
        end
    end

    task automatic check_outputs_zero(input string tag);
        check({tag, "_rdata0"}, c_rdata[31:0], 32'd0);
        check({tag, "_rdata1"}, c_rdata[63:32], 32'd0);
        check({tag, "_acks"}, {29'd0, c_wack, c_rack}, 32'd0);
        check({tag, "_maddr"}, m_addr, 32'd0);
        check({tag, "_strobe"}, {30'd0, m_re, m_we}, 32'd0);
        check({tag, "_mdout"}, {24'd0, m_dout}, 32'd0);
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        c_re = '0;
        c_we = '0;
        bq.delete();
        cq.delete();
        mptr = 0;
        for (int i = 0; i < NR; i++) exp_rdata[i] = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        repeat (2) @(posedge clk);
    endtask

    task automatic serve(input int sel);
        bit [31:0] ad;
        logic [31:0] w;
        logic [7:0] by;
        w = '0;
        for (int b = 0; b <= int'(b_len[sel]); b++) begin
            ad = b_addr[sel] + 32'(b);
            if (sel < NR) begin
                by = mdl_rd(ad);
                w = w | (32'(by) << (8 * b));
                bq.push_back('{1'b0, ad, 8'h00});
            end else begin
                by = 8'(b_wdata[sel] >> (8 * b));
                mdl_mem[ad] = by;
                bq.push_back('{1'b1, ad, by});
            end
        end
        if (sel < NR) begin
            cq.push_back('{1'b0, sel, w});
            exp_rdata[sel] = w;
        end else begin
            cq.push_back('{1'b1, sel - NR, 32'd0});
        end
    endtask

    task automatic run_batch(input logic [NA-1:0] set);
        logic [NA-1:0] rem;
        logic [NA-1:0] cand;
        int sel;
        bit found;
        int n;
        rem = set;
        while (rem != '0) begin
            cand = rem;
`ifdef MEM_ARB_WPRIO_EN
            if (rem[NA-1:NR] != '0) cand = rem & {{NW{1'b1}}, {NR{1'b0}}};
`endif
            found = 1'b0;
            sel = 0;
            for (int k = 0; k < NA; k++) begin
                if (!found && cand[(mptr + k) % NA]) begin
                    found = 1'b1;
                    sel = (mptr + k) % NA;
                end
            end
            mptr = (sel + 1) % NA;
            rem[sel] = 1'b0;
            serve(sel);
        end
        @(posedge clk); #2;
        for (int i = 0; i < NR; i++) begin
            c_raddr[i*32 +: 32] = b_addr[i];
            c_rlen[i*2 +: 2] = b_len[i];
        end
        for (int j = 0; j < NW; j++) begin
            c_waddr[j*32 +: 32] = b_addr[NR+j];
            c_wlen[j*2 +: 2] = b_len[NR+j];
            c_wdata[j*32 +: 32] = b_wdata[NR+j];
        end
        c_re = set[NR-1:0];
        c_we = set[NA-1:NR];
        n = 0;
        while (n < 1000) begin
            @(posedge clk); #3;
            if (cq.size() == 0 && c_re == '0 && c_we == '0) break;
            n++;
        end
        if (n >= 1000) begin
            tests++; fails++;
            $display("FAIL batch_timeout: %0d completions still due", cq.size());
            do_reset();
        end else begin
            repeat (3) @(posedge clk);
            #1;
            check("bus_drained", bq.size(), 32'd0);
            for (int i = 0; i < NR; i++)
                check("rdata_hold", c_rdata[i*32 +: 32], exp_rdata[i]);
        end
    endtask

    function automatic logic [31:0] rand_addr();
        case ($urandom_range(0, 3))
            0: return 32'hFFFF_FFFC + 32'($urandom_range(0, 3));
            1: return 32'h0000_1000 + 32'($urandom_range(0, 12));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int n;
        for (int i = 0; i < NR; i++) exp_rdata[i] = '0;
        for (int i = 0; i < NA; i++) begin
            b_addr[i] = '0; b_len[i] = '0; b_wdata[i] = '0;
        end

        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 check_outputs_zero("reset");
        rst = 1'b0;
        repeat (2) @(posedge clk);

        // read port0 of four preloaded bytes
        for (int b = 0; b < 4; b++) begin
            env_mem[32'h100 + 32'(b)] = 8'(8'h11 * (b + 1));
            mdl_mem[32'h100 + 32'(b)] = 8'(8'h11 * (b + 1));
        end
        b_addr[0] = 32'h100; b_len[0] = 2'd3;
        run_batch(3'b001);
        check("read4_word", c_rdata[31:0], 32'h4433_2211);

        // two-byte write, then one-byte read of it from port1
        b_addr[2] = 32'h20; b_len[2] = 2'd1; b_wdata[2] = 32'hAABB_CCDD;
        run_batch(3'b100);
        check("write_byte0", {24'd0, env_rd(32'h20)}, 32'h0000_00DD);
        check("write_byte1", {24'd0, env_rd(32'h21)}, 32'h0000_00CC);
        b_addr[1] = 32'h20; b_len[1] = 2'd0;
        run_batch(3'b010);
        check("read1_zero_ext", c_rdata[63:32], 32'h0000_00DD);

        // address wrap past the top of memory
        b_addr[1] = 32'hFFFF_FFFF; b_len[1] = 2'd1;
        run_batch(3'b010);

        // reset after the first byte of a four-byte read
        b_addr[0] = 32'h300; b_len[0] = 2'd3;
        for (int b = 0; b < 4; b++) bq.push_back('{1'b0, 32'h300 + 32'(b), 8'h00});
        n = bus_acks;
        @(posedge clk); #2;
        c_raddr[31:0] = 32'h300;
        c_rlen[1:0] = 2'd3;
        c_re = 2'b01;
        for (int k = 0; k < 200 && bus_acks == n; k++) @(posedge clk);
        check("rst_first_byte", 32'(bus_acks - n), 32'd1);
        @(posedge clk); #1;
        rst = 1'b1;
        #1 check_outputs_zero("midrst");
        c_re = '0;
        bq.delete();
        cq.delete();
        mptr = 0;
        for (int i = 0; i < NR; i++) exp_rdata[i] = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        repeat (2) @(posedge clk);

        // all three ports request together from pointer 0
        for (int i = 0; i < NA; i++) begin
            b_addr[i] = 32'h400 + 32'(16 * i);
            b_len[i] = 2'(i + 1);
            b_wdata[i] = $urandom;
        end
        run_batch(3'b111);

        // slow memory: five stall cycles per byte with idle glitches
        force_stall = 5;
        b_addr[0] = 32'h404; b_len[0] = 2'd3;
        b_addr[2] = 32'h405; b_len[2] = 2'd2; b_wdata[2] = 32'h1234_5678;
        run_batch(3'b101);
        force_stall = -1;

        // randomized batches
        for (int t = 0; t < 40; t++) begin
            for (int i = 0; i < NA; i++) begin
                b_addr[i] = rand_addr();
                b_len[i] = 2'($urandom_range(0, 3));
                b_wdata[i] = $urandom;
            end
            run_batch(3'($urandom_range(1, 7)));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: bench did not finish");
        $fatal(1, "timeout");
    end

endmodule
